// File: rtl/hwpe_buffer_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hwpe_buffer_pkg
//  Description : Shared widths and packed output-word type for the
//                hwpe_buffer stage and its upstream width packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package hwpe_buffer_pkg;

    localparam int unsigned IN_WIDTH_DEF     = 8;
    localparam int unsigned BUFFER_WIDTH_DEF = 32;
    localparam int unsigned RATIO_DEF        = BUFFER_WIDTH_DEF / IN_WIDTH_DEF;

    // Packed buffer word at the default widths: data, per-lane strobe, last.
    typedef struct packed {
        logic [BUFFER_WIDTH_DEF-1:0] data;
        logic [RATIO_DEF-1:0]        strb;
        logic                        last;
    } buffer_word_t;

endpackage
`default_nettype wire

// File: rtl/hwpe_buffer_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : hwpe_buffer_packer_if
//  Description : Narrow input stream and packed output stream of the
//                buffer packer, grouped as one interface.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hwpe_buffer_packer_if
    import hwpe_buffer_pkg::*;
#(
    parameter int unsigned IN_WIDTH     = IN_WIDTH_DEF,
    parameter int unsigned BUFFER_WIDTH = BUFFER_WIDTH_DEF
);
    localparam int unsigned RATIO = BUFFER_WIDTH / IN_WIDTH;

    logic [IN_WIDTH-1:0]     in_data_i;
    logic                    in_valid_i;
    logic                    in_last_i;
    logic                    in_ready_o;
    logic [BUFFER_WIDTH-1:0] out_data_o;
    logic [RATIO-1:0]        out_strb_o;
    logic                    out_last_o;
    logic                    out_valid_o;
    logic                    out_ready_i;

    // Environment side: produces beats, consumes words.
    modport master (
        output in_data_i, in_valid_i, in_last_i, out_ready_i,
        input  in_ready_o, out_data_o, out_strb_o, out_last_o, out_valid_o
    );

    // Packer side.
    modport slave (
        input  in_data_i, in_valid_i, in_last_i, out_ready_i,
        output in_ready_o, out_data_o, out_strb_o, out_last_o, out_valid_o
    );

endinterface
`default_nettype wire

// File: rtl/hwpe_buffer_packer.sv
`default_nettype none
// ============================================================================
//  Module      : hwpe_buffer_packer
//  Description : Packs RATIO consecutive IN_WIDTH beats into one
//                BUFFER_WIDTH word with per-lane strobes; a last beat closes
//                a word early. Output word is held in a register until taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module hwpe_buffer_packer
    import hwpe_buffer_pkg::*;
#(
    parameter int unsigned IN_WIDTH     = IN_WIDTH_DEF,
    parameter int unsigned BUFFER_WIDTH = BUFFER_WIDTH_DEF
) (
    input  wire logic           clk_i,
    input  wire logic           rst_ni,
    input  wire logic           clear_i,
    hwpe_buffer_packer_if.slave bus
);

    localparam int unsigned RATIO   = BUFFER_WIDTH / IN_WIDTH;
    localparam int unsigned c_CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_LANE = c_CNT_W'(RATIO - 1);

    // Same layout as buffer_word_t, sized by this instance's parameters.
    typedef struct packed {
        logic [BUFFER_WIDTH-1:0] data;
        logic [RATIO-1:0]        strb;
        logic                    last;
    } out_word_t;

    // Lanes must tile the output word exactly.
    if (BUFFER_WIDTH % IN_WIDTH != 0) begin : g_bad_width
        $error("hwpe_buffer_packer: BUFFER_WIDTH must be a multiple of IN_WIDTH");
    end

    logic [c_CNT_W-1:0]      r_cnt;
    logic [BUFFER_WIDTH-1:0] r_acc_data;
    logic [RATIO-1:0]        r_acc_strb;
    out_word_t               r_out;
    logic                    r_out_valid;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_complete;
    logic                    w_consume;
    logic [BUFFER_WIDTH-1:0] w_acc_data;
    logic [RATIO-1:0]        w_acc_strb;

    // Accept only when the output slot is free or being emptied this cycle.
    assign w_in_ready = !r_out_valid || bus.out_ready_i;
    assign w_accept   = bus.in_valid_i && w_in_ready;
    assign w_complete = w_accept && ((r_cnt == c_LAST_LANE) || bus.in_last_i);
    assign w_consume  = r_out_valid && bus.out_ready_i;

    // Accumulator contents including the beat arriving this cycle.
    always_comb begin
        w_acc_data = r_acc_data;
        w_acc_strb = r_acc_strb;
        w_acc_data[32'(r_cnt) * IN_WIDTH +: IN_WIDTH] = bus.in_data_i;
        w_acc_strb[r_cnt] = 1'b1;
    end

    // Lane counter, accumulator and output register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt       <= '0;
            r_acc_data  <= '0;
            r_acc_strb  <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (clear_i) begin
            r_cnt       <= '0;
            r_acc_data  <= '0;
            r_acc_strb  <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_complete) begin
                r_out.data  <= w_acc_data;
                r_out.strb  <= w_acc_strb;
                r_out.last  <= bus.in_last_i;
                r_out_valid <= 1'b1;
                r_cnt       <= '0;
                r_acc_data  <= '0;
                r_acc_strb  <= '0;
            end else begin
                if (w_accept) begin
                    r_acc_data <= w_acc_data;
                    r_acc_strb <= w_acc_strb;
                    r_cnt      <= r_cnt + c_CNT_W'(1);
                end
                if (w_consume) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_data_o  = r_out.data;
    assign bus.out_strb_o  = r_out.strb;
    assign bus.out_last_o  = r_out.last;
    assign bus.out_valid_o = r_out_valid;

    // A stalled word must not change until it is taken.
    a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_out_valid && !bus.out_ready_i && !clear_i) |=> (r_out_valid && $stable(r_out)));

endmodule
`default_nettype wire

// File: tb/tb_hwpe_buffer_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hwpe_buffer_packer
//  Description : Directed and random stimulus for hwpe_buffer_packer,
//                compared against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpe_buffer_packer;

    localparam int unsigned IN_W  = 8;
    localparam int unsigned BUF_W = 32;
    localparam int unsigned RATIO = BUF_W / IN_W;

    typedef struct {
        logic [BUF_W-1:0] data;
        logic [RATIO-1:0] strb;
        logic             last;
    } word_t;

    logic clk_i;
    logic rst_ni;
    logic clear_i;

    hwpe_buffer_packer_if #(.IN_WIDTH(IN_W), .BUFFER_WIDTH(BUF_W)) bus ();

    hwpe_buffer_packer #(.IN_WIDTH(IN_W), .BUFFER_WIDTH(BUF_W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: beats gathered for the open word, and words waiting
    // at the output (at most one can wait).
    logic [IN_W-1:0] q_beats[$];
    word_t           q_words[$];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic l,
                         input logic rdy, input logic clr);
        bus.in_valid_i  = v;
        bus.in_data_i   = d;
        bus.in_last_i   = l;
        bus.out_ready_i = rdy;
        clear_i         = clr;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the
    // model with the handshakes that happen at the rising edge.
    task automatic cycle();
        logic  exp_valid;
        logic  accept;
        word_t w;
        @(negedge clk_i);
        exp_valid = (q_words.size() != 0);
        check("in_ready", 64'(bus.in_ready_o), 64'(!exp_valid || bus.out_ready_i));
        check("out_valid", 64'(bus.out_valid_o), 64'(exp_valid));
        if (exp_valid) begin
            check("out_data", 64'(bus.out_data_o), 64'(q_words[0].data));
            check("out_strb", 64'(bus.out_strb_o), 64'(q_words[0].strb));
            check("out_last", 64'(bus.out_last_o), 64'(q_words[0].last));
        end
        accept = bus.in_valid_i && (!exp_valid || bus.out_ready_i);
        @(posedge clk_i);
        if (clear_i) begin
            q_beats.delete();
            q_words.delete();
        end else begin
            if (exp_valid && bus.out_ready_i) void'(q_words.pop_front());
            if (accept) begin
                q_beats.push_back(bus.in_data_i);
                if (q_beats.size() == RATIO || bus.in_last_i) begin
                    w.data = '0;
                    w.strb = '0;
                    foreach (q_beats[i]) begin
                        w.data[i*IN_W +: IN_W] = q_beats[i];
                        w.strb[i] = 1'b1;
                    end
                    w.last = bus.in_last_i;
                    q_words.push_back(w);
                    q_beats.delete();
                end
            end
        end
        #1;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        #1 rst_ni = 1'b0;
        #1;
        check({tag, "_valid"}, 64'(bus.out_valid_o), 64'd0);
        check({tag, "_data"},  64'(bus.out_data_o),  64'd0);
        check({tag, "_strb"},  64'(bus.out_strb_o),  64'd0);
        check({tag, "_last"},  64'(bus.out_last_o),  64'd0);
        q_beats.delete();
        q_words.delete();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        check({tag, "_ready"}, 64'(bus.in_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        @(posedge clk_i);
        #1;
        do_reset("reset");

        // Full word closed by last on the fourth beat.
        drive(1'b1, 8'h11, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b1, 8'h22, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b1, 8'h33, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b1, 8'h44, 1'b1, 1'b1, 1'b0); cycle();
        check("t1_data",  64'(bus.out_data_o),  64'h44332211);
        check("t1_strb",  64'(bus.out_strb_o),  64'hF);
        check("t1_last",  64'(bus.out_last_o),  64'd1);
        check("t1_valid", 64'(bus.out_valid_o), 64'd1);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0); cycle();
        check("t1_drop", 64'(bus.out_valid_o), 64'd0);

        // Short word of three beats.
        drive(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0); cycle();
        check("t2_data", 64'(bus.out_data_o), 64'h00CCBBAA);
        check("t2_strb", 64'(bus.out_strb_o), 64'h7);
        check("t2_last", 64'(bus.out_last_o), 64'd1);

        // Continuous beats, two full words.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
            cycle();
            if (i == 3) check("t3_word0", 64'(bus.out_data_o), 64'h03020100);
            if (i == 7) check("t3_word1", 64'(bus.out_data_o), 64'h07060504);
        end
        check("t3_strb", 64'(bus.out_strb_o), 64'hF);
        check("t3_last", 64'(bus.out_last_o), 64'd0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0); cycle();

        // Backpressure with a pending word, then release with a completing beat.
        drive(1'b1, 8'h10, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 8'h20, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 8'h30, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 8'h40, 1'b0, 1'b0, 1'b0); cycle();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'h50, 1'b1, 1'b0, 1'b0);
            cycle();
            check("t4_stall_ready", 64'(bus.in_ready_o), 64'd0);
            check("t4_stall_data",  64'(bus.out_data_o), 64'h40302010);
        end
        drive(1'b1, 8'h50, 1'b1, 1'b1, 1'b0); cycle();
        check("t4_reload_valid", 64'(bus.out_valid_o), 64'd1);
        check("t4_reload_data",  64'(bus.out_data_o),  64'h00000050);
        check("t4_reload_strb",  64'(bus.out_strb_o),  64'h1);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0); cycle();

        // Soft clear drops a partial word and a beat presented with it.
        drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b1, 8'h02, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1); cycle();
        check("t5_clear_valid", 64'(bus.out_valid_o), 64'd0);
        for (int i = 5; i <= 8; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
            cycle();
        end
        check("t5_data", 64'(bus.out_data_o), 64'h08070605);
        check("t5_strb", 64'(bus.out_strb_o), 64'hF);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0); cycle();

        // Reset mid-word, then with a stalled word pending.
        drive(1'b1, 8'h61, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b1, 8'h62, 1'b0, 1'b1, 1'b0); cycle();
        do_reset("t6_midword");
        drive(1'b1, 8'h71, 1'b1, 1'b1, 1'b0); cycle();
        check("t6_lane0_data", 64'(bus.out_data_o), 64'h00000071);
        check("t6_lane0_strb", 64'(bus.out_strb_o), 64'h1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h81 + 8'(i), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        check("t6_pending", 64'(bus.out_valid_o), 64'd1);
        do_reset("t6_pending");

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 19) < 3),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
            cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
